// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch input, write-back port, ID/EX register outputs and the jump
// request back to fetch.
interface decode_stage_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 3
);
  logic [W-1:0]  instr;
  logic          flush;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;

  logic          ex_valid;
  logic [4:0]    ex_opcode;
  logic [W-1:0]  ex_src_val;
  logic [W-1:0]  ex_dst_val;
  logic [W-1:0]  ex_imm;
  logic [AW-1:0] ex_rdst;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          direct_jump;
  logic [W-1:0]  direct_jump_to;

  // Decode stage view.
  modport master (
    input  instr, flush, wb_en, wb_addr, wb_data,
    output ex_valid, ex_opcode, ex_src_val, ex_dst_val, ex_imm, ex_rdst,
           ex_reg_write, ex_mem_read, ex_mem_write, direct_jump, direct_jump_to
  );

  // Surrounding pipeline view.
  modport slave (
    output instr, flush, wb_en, wb_addr, wb_data,
    input  ex_valid, ex_opcode, ex_src_val, ex_dst_val, ex_imm, ex_rdst,
           ex_reg_write, ex_mem_read, ex_mem_write, direct_jump, direct_jump_to
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode: register file with write-first bypass, two-word LDM assembly,
// ID/EX pipeline register and direct-jump request to fetch.
module decode_stage #(
  parameter int unsigned REGS = 8,
  parameter int unsigned W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.master bus
);
  localparam int unsigned AW = $clog2(REGS);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StWaitImm = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  ldm_q, ldm_d;
  logic [W-1:0]  rf_q [REGS];

  logic          valid_q, valid_d;
  logic [4:0]    opcode_q, opcode_d;
  logic [W-1:0]  src_q, src_d;
  logic [W-1:0]  dst_q, dst_d;
  logic [W-1:0]  imm_q, imm_d;
  logic [AW-1:0] rdst_q, rdst_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          jump_q, jump_d;
  logic [W-1:0]  jump_to_q, jump_to_d;

  logic [W-1:0]  dec_word;
  logic [4:0]    op;
  logic [AW-1:0] rs_idx, rt_idx;
  logic [W-1:0]  src_val, dst_val;

  // While waiting for the immediate, operand indices come from the latched LDM word.
  assign dec_word = (state_q == StWaitImm) ? ldm_q : bus.instr;
  assign op       = dec_word[15:11];
  assign rs_idx   = dec_word[10:8];
  assign rt_idx   = dec_word[7:5];

  assign src_val = (bus.wb_en && bus.wb_addr == rs_idx) ? bus.wb_data : rf_q[rs_idx];
  assign dst_val = (bus.wb_en && bus.wb_addr == rt_idx) ? bus.wb_data : rf_q[rt_idx];

  always_comb begin
    state_d     = StIdle;
    ldm_d       = ldm_q;
    valid_d     = 1'b0;
    opcode_d    = '0;
    src_d       = '0;
    dst_d       = '0;
    imm_d       = '0;
    rdst_d      = '0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    jump_d      = 1'b0;
    jump_to_d   = '0;

    if (bus.flush) begin
      // Bubble and return to idle; nothing else to do.
    end else if (state_q == StWaitImm) begin
      valid_d     = 1'b1;
      opcode_d    = op;
      src_d       = src_val;
      dst_d       = dst_val;
      imm_d       = bus.instr;
      rdst_d      = rs_idx;
      reg_write_d = 1'b1;
    end else begin
      case (op) inside
        [5'd1:5'd8]: begin
          valid_d     = 1'b1;
          opcode_d    = op;
          src_d       = src_val;
          dst_d       = dst_val;
          rdst_d      = rt_idx;
          reg_write_d = 1'b1;
        end
        5'd9: begin
          ldm_d   = bus.instr;
          state_d = StWaitImm;
        end
        5'd10: begin
          valid_d     = 1'b1;
          opcode_d    = op;
          src_d       = src_val;
          dst_d       = dst_val;
          rdst_d      = rt_idx;
          reg_write_d = 1'b1;
          mem_read_d  = 1'b1;
        end
        5'd11: begin
          valid_d     = 1'b1;
          opcode_d    = op;
          src_d       = src_val;
          dst_d       = dst_val;
          mem_write_d = 1'b1;
        end
        5'd12: begin
          jump_d    = 1'b1;
          jump_to_d = src_val;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ldm_q       <= '0;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      imm_q       <= '0;
      rdst_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      jump_q      <= 1'b0;
      jump_to_q   <= '0;
    end else begin
      state_q     <= state_d;
      ldm_q       <= ldm_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      imm_q       <= imm_d;
      rdst_q      <= rdst_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      jump_q      <= jump_d;
      jump_to_q   <= jump_to_d;
    end
  end

  // Write-back is independent of flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REGS); i++) rf_q[i] <= '0;
    end else if (bus.wb_en) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  assign bus.ex_valid       = valid_q;
  assign bus.ex_opcode      = opcode_q;
  assign bus.ex_src_val     = src_q;
  assign bus.ex_dst_val     = dst_q;
  assign bus.ex_imm         = imm_q;
  assign bus.ex_rdst        = rdst_q;
  assign bus.ex_reg_write   = reg_write_q;
  assign bus.ex_mem_read    = mem_read_q;
  assign bus.ex_mem_write   = mem_write_q;
  assign bus.direct_jump    = jump_q;
  assign bus.direct_jump_to = jump_to_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: single-cycle decode table plus LDM, flush, jump and
// reset sequences.
module tb_decode_stage;
  logic clk;
  logic rst;

  decode_stage_if dif ();

  decode_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] instr;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [76:0] exp;
  } vec_t;

  vec_t vecs [16];

  // {valid, opcode, src, dst, imm, rdst, reg_write, mem_read, mem_write, jump, jump_to}
  function automatic logic [76:0] e(input logic v, input logic [4:0] op, input logic [15:0] s,
                                    input logic [15:0] d, input logic [15:0] imm,
                                    input logic [2:0] rd, input logic rw, input logic mr,
                                    input logic mw, input logic j, input logic [15:0] jt);
    return {v, op, s, d, imm, rd, rw, mr, mw, j, jt};
  endfunction

  function automatic vec_t mk(input logic [15:0] instr, input logic we, input logic [2:0] wa,
                              input logic [15:0] wd, input logic [76:0] exp);
    vec_t r;
    r.instr   = instr;
    r.wb_en   = we;
    r.wb_addr = wa;
    r.wb_data = wd;
    r.exp     = exp;
    return r;
  endfunction

  function automatic logic [76:0] outs();
    return {dif.ex_valid, dif.ex_opcode, dif.ex_src_val, dif.ex_dst_val, dif.ex_imm,
            dif.ex_rdst, dif.ex_reg_write, dif.ex_mem_read, dif.ex_mem_write,
            dif.direct_jump, dif.direct_jump_to};
  endfunction

  task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] instr, input logic flush, input logic we,
                       input logic [2:0] wa, input logic [15:0] wd);
    dif.instr   = instr;
    dif.flush   = flush;
    dif.wb_en   = we;
    dif.wb_addr = wa;
    dif.wb_data = wd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam logic [76:0] Zero = '0;

  initial begin
    rst = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);

    vecs[0]  = mk(16'h0000, 1'b1, 3'd5, 16'h0007, Zero);
    vecs[1]  = mk(16'h0000, 1'b1, 3'd6, 16'h0040, Zero);
    vecs[2]  = mk(16'h0000, 1'b1, 3'd1, 16'h1111, Zero);
    vecs[3]  = mk(16'h0000, 1'b1, 3'd3, 16'h3333, Zero);
    // ALU op1 rs=2 rt=5 with same-cycle write of R2
    vecs[4]  = mk(16'h0AA0, 1'b1, 3'd2, 16'hBEEF,
                  e(1, 5'd1, 16'hBEEF, 16'h0007, 16'h0, 3'd5, 1, 0, 0, 0, 16'h0));
    vecs[5]  = mk(16'h4160, 1'b0, 3'd0, 16'h0000,
                  e(1, 5'd8, 16'h1111, 16'h3333, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0));
    vecs[6]  = mk(16'h5620, 1'b0, 3'd0, 16'h0000,
                  e(1, 5'd10, 16'h0040, 16'h1111, 16'h0, 3'd1, 1, 1, 0, 0, 16'h0));
    vecs[7]  = mk(16'h5B40, 1'b0, 3'd0, 16'h0000,
                  e(1, 5'd11, 16'h3333, 16'hBEEF, 16'h0, 3'd0, 0, 0, 1, 0, 16'h0));
    vecs[8]  = mk(16'hA120, 1'b1, 3'd1, 16'h2222, Zero);
    vecs[9]  = mk(16'h6600, 1'b0, 3'd0, 16'h0000,
                  e(0, 5'd0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0040));
    vecs[10] = mk(16'h0000, 1'b0, 3'd0, 16'h0000, Zero);
    vecs[11] = mk(16'h6700, 1'b1, 3'd7, 16'h0123,
                  e(0, 5'd0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0123));
    vecs[12] = mk(16'h6600, 1'b0, 3'd0, 16'h0000,
                  e(0, 5'd0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 1, 16'h0040));
    vecs[13] = mk(16'h6800, 1'b0, 3'd0, 16'h0000, Zero);
    vecs[14] = mk(16'h0000, 1'b1, 3'd0, 16'hA5A5, Zero);
    vecs[15] = mk(16'h0800, 1'b0, 3'd0, 16'h0000,
                  e(1, 5'd1, 16'hA5A5, 16'hA5A5, 16'h0, 3'd0, 1, 0, 0, 0, 16'h0));

    cyc();
    cyc();
    rst = 1'b0;
    chk("reset_outputs", outs(), Zero);

    foreach (vecs[i]) begin
      drive(vecs[i].instr, 1'b0, vecs[i].wb_en, vecs[i].wb_addr, vecs[i].wb_data);
      cyc();
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // LDM rs=4 with a zero immediate: bubble, then the assembled instruction
    drive(16'h4C00, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("ldm_bubble", outs(), Zero);
    drive(16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("ldm_imm0", {dif.ex_valid, dif.ex_opcode, dif.ex_imm, dif.ex_rdst, dif.ex_reg_write,
                     dif.ex_mem_read, dif.ex_mem_write, dif.direct_jump},
        {1'b1, 5'd9, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0});
    cyc();
    chk("ldm_back_idle", outs(), Zero);

    // LDM whose immediate looks like an ALU instruction
    drive(16'h4C00, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    drive(16'h0AA0, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("ldm_imm_alu_like", {dif.ex_valid, dif.ex_opcode, dif.ex_imm, dif.ex_rdst,
                             dif.ex_reg_write},
        {1'b1, 5'd9, 16'h0AA0, 3'd4, 1'b1});

    // Flush while waiting for the immediate
    drive(16'h4C00, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    drive(16'hABCD, 1'b1, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("flush_wait_imm", outs(), Zero);
    drive(16'h0AA0, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("after_flush_alu", outs(),
        e(1, 5'd1, 16'hBEEF, 16'h0007, 16'h0, 3'd5, 1, 0, 0, 0, 16'h0));

    // Flush beats JMP; write-back still lands during flush
    drive(16'h6600, 1'b1, 1'b1, 3'd4, 16'h4444);
    cyc();
    chk("flush_jmp", outs(), Zero);
    drive(16'h0C80, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("wb_during_flush", outs(),
        e(1, 5'd1, 16'h4444, 16'h4444, 16'h0, 3'd4, 1, 0, 0, 0, 16'h0));

    // Asynchronous reset mid-cycle
    drive(16'h0AA0, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", outs(), Zero);
    cyc();
    rst = 1'b0;
    drive(16'h0B60, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("rf_cleared", outs(), e(1, 5'd1, 16'h0, 16'h0, 16'h0, 3'd3, 1, 0, 0, 0, 16'h0));

    // Reset mid-LDM drops the pending opcode
    drive(16'h4C00, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(16'h0AA0, 1'b0, 1'b0, 3'd0, 16'h0000);
    cyc();
    chk("reset_mid_ldm", outs(), e(1, 5'd1, 16'h0, 16'h0, 16'h0, 3'd5, 1, 0, 0, 0, 16'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
